vga_timing_gen: RTL

Raster timing generator for the 640x480 @ 60 Hz display path. It runs at the pixel rate on `vga_clk` and produces the scan position (`DrawX`, `DrawY`), the active-video flag `blank`, and the active-low sync pulses. The sprite and background renderers consume these signals to address their ROMs and gate their colour outputs. It also produces per-frame strobes and a frame counter that game logic uses to pace animation.

---
 rtl/vga_timing_gen.sv | 83 ++++++++
 1 files changed

// File: rtl/vga_timing_gen.sv
// Raster timing generator: scan position, active-video flag, syncs,
// per-frame strobes and a free-running frame counter.
module vga_timing_gen #(
    parameter int H_VISIBLE = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33
) (
    input  logic        vga_clk,
    input  logic        reset,
    output logic [9:0]  DrawX,
    output logic [9:0]  DrawY,
    output logic        blank,
    output logic        hs,
    output logic        vs,
    output logic        sync,
    output logic        frame_start,
    output logic        vblank_start,
    output logic [15:0] frame_count
);

    localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

    generate
        if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_total
            $error("vga_timing_gen: H_TOTAL/V_TOTAL exceed 1024");
        end
    endgenerate

    localparam logic [9:0] H_LAST  = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST  = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS   = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS   = 10'(V_VISIBLE);
    localparam logic [9:0] HS_BEG  = 10'(H_VISIBLE + H_FP);
    localparam logic [9:0] HS_END  = 10'(H_VISIBLE + H_FP + H_SYNC);
    localparam logic [9:0] VS_BEG  = 10'(V_VISIBLE + V_FP);
    localparam logic [9:0] VS_END  = 10'(V_VISIBLE + V_FP + V_SYNC);

    logic [9:0] x_nxt;
    logic [9:0] y_nxt;
    logic       at_origin;

    always_comb begin
        x_nxt = DrawX + 10'd1;
        y_nxt = DrawY;
        if (DrawX == H_LAST) begin
            x_nxt = '0;
            y_nxt = (DrawY == V_LAST) ? 10'd0 : DrawY + 10'd1;
        end
    end

    assign at_origin = (x_nxt == 10'd0) && (y_nxt == 10'd0);
    assign sync      = 1'b0;

    // Flags decode the next position so they line up with DrawX/DrawY.
    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            DrawX        <= H_LAST;
            DrawY        <= V_LAST;
            blank        <= 1'b0;
            hs           <= 1'b1;
            vs           <= 1'b1;
            frame_start  <= 1'b0;
            vblank_start <= 1'b0;
            frame_count  <= 16'hFFFF;
        end else begin
            DrawX        <= x_nxt;
            DrawY        <= y_nxt;
            blank        <= (x_nxt < H_VIS) && (y_nxt < V_VIS);
            hs           <= !((x_nxt >= HS_BEG) && (x_nxt < HS_END));
            vs           <= !((y_nxt >= VS_BEG) && (y_nxt < VS_END));
            frame_start  <= at_origin;
            vblank_start <= (x_nxt == 10'd0) && (y_nxt == V_VIS);
            frame_count  <= frame_count + 16'(at_origin);
        end
    end

endmodule
